fp_mul_pipe: RTL
================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready flow control.
//  Generalises the half-precision combinational multiplier: configurable exponent/mantissa width,
//  round-to-nearest-even, special-value handling and exception flags. Sits between the scoreboard
//  issue logic and the FP writeback bus as the FMUL functional unit.
// PARAMETERS
//  EXP_W   5    exponent field width; BIAS = 2**(EXP_W-1)-1
//  MAN_W   10   stored mantissa field width (hidden 1 implied); W = 1+EXP_W+MAN_W (16 = binary16)
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operand pair valid
//  in_ready   out  1  unit accepts operands this cycle
//  in_a       in   W  operand A {sign, exp, man}
//  in_b       in   W  operand B
//  out_valid  out  1  result valid
//  out_ready  in   1  downstream accepts result
//  out_p      out  W  product
//  out_ovf    out  1  overflow: finite*finite rounded above max finite
//  out_udf    out  1  underflow: nonzero*nonzero flushed to zero
//  out_inv    out  1  invalid: NaN input or inf*0
// BEHAVIOUR
//  Reset: all stage valid bits, out_valid, out_p, flags = 0; in-flight ops discarded, none emitted after.
//  Handshake: transfer on in_valid&in_ready / out_valid&out_ready. in_ready = !out_valid | out_ready.
//   Single global stall: whole pipe holds when out_valid & !out_ready; out_p/flags stable while stalled.
//   Bubbles advance; throughput 1 op/cycle unstalled. Latency exactly 3 cycles accept->out_valid.
//  S1 unpack: sign = a.s XOR b.s; classify zero (exp==0, any man: subnormals flushed to zero),
//   inf (exp all-ones, man==0), NaN (exp all-ones, man!=0). Exponent sum ea+eb-BIAS in EXP_W+2-bit signed.
//  S2 multiply: {1,ma}*{1,mb} -> 2*MAN_W+2-bit unsigned product, carry class/sign/exp alongside.
//  S3 normalise/round/pack:
//   product MSB set -> shift right 1, exp+1. Keep MAN_W bits; guard = next bit, sticky = OR of rest.
//   RNE: round up if guard & (sticky | lsb). Mantissa carry-out -> man=0, exp+1.
//   biased exp >= all-ones -> out_p = {sign, all-ones, 0} (inf), out_ovf=1.
//   biased exp <= 0 -> out_p = {sign, 0...0}, out_udf=1.
//  Specials (override S3 arithmetic, flags other than listed = 0):
//   any NaN input, or inf*zero -> canonical qNaN {0, all-ones, 1<<(MAN_W-1)}, out_inv=1.
//   inf*finite-nonzero or inf*inf -> {sign, inf}, no flag.
//   zero*finite -> {sign, 0}, no flag.
//  Flags are valid only with out_valid; zero when out_valid=0.
// TESTING
//  1) 0x3C00*0x3C00 (1.0*1.0) -> 0x3C00, flags 0, out_valid exactly 3 cycles after accept.
//  2) 0x3E00*0x3E00 (1.5*1.5) -> 0x4080; 0xBC00*0x3C00 -> 0xBC00 (sign XOR).
//  3) RNE: 0x3C01*0x3E00 (tie, odd lsb) -> 0x3E02; 0x3C01*0x3C01 -> 0x3C02 (below half, truncate).
//  4) 0x7BFF*0x7BFF -> 0x7C00, out_ovf=1; 0x0400*0x0400 -> 0x0000, out_udf=1; 0x8000*0x3C00 -> 0x8000.
//  5) 0x7C00*0x0000 -> 0x7E00 out_inv=1; 0x7C01*0x3C00 -> 0x7E00 out_inv=1; 0xFC00*0x3C00 -> 0xFC00.
//  6) Back-to-back 8 ops with out_ready toggling 1,0,0,1..: results in order, none lost/duplicated,
//     out_p stable while stalled; assert rst mid-stream -> out_valid=0 next cycle, no stale outputs.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack, multiply, then normalise/round (RNE)/pack.
// Latency 3 cycles. A stalled output holds the entire pipe. Subnormal inputs are flushed to zero.
module fp_mul_pipe #(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_ovf,
  output logic         out_udf,
  output logic         out_inv
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX_S = EW2'((1 << EXP_W) - 1);
  localparam logic [MAN_W-1:0]      QNAN_M = {1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic                  sgn;
    logic                  inv;
    logic                  inf;
    logic                  zero;
    logic signed [EW2-1:0] exp;
    logic [MAN_W:0]        ma;
    logic [MAN_W:0]        mb;
  } s1_t;

  typedef struct packed {
    logic                  sgn;
    logic                  inv;
    logic                  inf;
    logic                  zero;
    logic signed [EW2-1:0] exp;
    logic [PW-1:0]         prod;
  } s2_t;

  s1_t          s1_d, s1_q;
  s2_t          s2_d, s2_q;
  logic         s1_vld_q, s2_vld_q, out_vld_q;
  logic [W-1:0] p_d, p_q;
  logic         ovf_d, ovf_q, udf_d, udf_q, inv_d, inv_q;
  logic         adv;

  assign adv       = !out_vld_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign out_p     = p_q;
  assign out_ovf   = ovf_q;
  assign out_udf   = udf_q;
  assign out_inv   = inv_q;

  // S1: operand classification and biased exponent sum
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {a_s, a_e, a_m} = in_a;
  assign {b_s, b_e, b_m} = in_b;

  always_comb begin
    a_zero    = (a_e == '0);
    b_zero    = (b_e == '0);
    a_inf     = (&a_e) && (a_m == '0);
    b_inf     = (&b_e) && (b_m == '0);
    a_nan     = (&a_e) && (a_m != '0);
    b_nan     = (&b_e) && (b_m != '0);
    s1_d.sgn  = a_s ^ b_s;
    s1_d.inv  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    s1_d.inf  = a_inf || b_inf;
    s1_d.zero = a_zero || b_zero;
    s1_d.exp  = $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - BIAS_S;
    s1_d.ma   = {1'b1, a_m};
    s1_d.mb   = {1'b1, b_m};
  end

  // S2: significand product
  always_comb begin
    s2_d.sgn  = s1_q.sgn;
    s2_d.inv  = s1_q.inv;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero;
    s2_d.exp  = s1_q.exp;
    s2_d.prod = PW'(s1_q.ma) * PW'(s1_q.mb);
  end

  // S3: normalise so the leading one sits just above the kept mantissa, then round
  logic [PW-2:0]         norm;
  logic [MAN_W-1:0]      man;
  logic                  guard, sticky, rnd;
  logic [MAN_W:0]        man_r;
  logic signed [EW2-1:0] exp_n;

  always_comb begin
    norm   = s2_q.prod[PW-1] ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
    man    = norm[PW-2 -: MAN_W];
    guard  = norm[PW-2-MAN_W];
    sticky = |norm[PW-3-MAN_W:0];
    rnd    = guard && (sticky || man[0]);
    man_r  = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
    exp_n  = s2_q.exp
           + $signed({{(EW2-1){1'b0}}, s2_q.prod[PW-1]})
           + $signed({{(EW2-1){1'b0}}, man_r[MAN_W]});
    p_d    = {s2_q.sgn, exp_n[EXP_W-1:0], man_r[MAN_W-1:0]};
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    inv_d  = 1'b0;
    if (s2_q.inv) begin
      p_d   = {1'b0, {EXP_W{1'b1}}, QNAN_M};
      inv_d = 1'b1;
    end else if (s2_q.inf) begin
      p_d = {s2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_q.zero) begin
      p_d = {s2_q.sgn, {(W-1){1'b0}}};
    end else if (exp_n >= EMAX_S) begin
      p_d   = {s2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (exp_n[EW2-1] || (exp_n == '0)) begin
      p_d   = {s2_q.sgn, {(W-1){1'b0}}};
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      p_q       <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else if (adv) begin
      s1_vld_q  <= in_valid;
      s2_vld_q  <= s1_vld_q;
      out_vld_q <= s2_vld_q;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      // bubbles clear the result so flags read zero whenever out_valid is low
      p_q       <= s2_vld_q ? p_d : '0;
      ovf_q     <= s2_vld_q && ovf_d;
      udf_q     <= s2_vld_q && udf_d;
      inv_q     <= s2_vld_q && inv_d;
    end
  end

endmodule
